// File: rtl/adaptive_filter_pipe.sv
// Streaming FIR with optional integrator: delay line + registered products, then
// rounded accumulation, then saturating output stage. Mode changes drain and clear the pipe.
module adaptive_filter_pipe #(
  parameter int DATA_WIDTH  = 14,
  parameter int COEFF_WIDTH = 16,
  parameter int COEFF_FRAC  = 14,
  parameter int TAPS        = 8,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [1:0]                    mode,
  input  logic                          s_tvalid,
  output logic                          s_tready,
  input  logic signed [DATA_WIDTH-1:0]  s_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic signed [OUT_WIDTH-1:0]   m_tdata,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEFF_WIDTH-1:0] coef_data,
  input  logic                          coef_commit,
  output logic [1:0]                    mode_active,
  output logic                          sat_flag,
  output logic                          busy
);

  localparam int PW = DATA_WIDTH + COEFF_WIDTH;
  localparam int AW = DATA_WIDTH + COEFF_WIDTH + $clog2(TAPS) + 1;
  localparam int SW = AW + 1;
  localparam logic signed [AW-1:0] RND = AW'(1 << (COEFF_FRAC - 1));
  localparam logic signed [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(1 << COEFF_FRAC);

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t state_q, state_d;
  logic [1:0] mode_active_q, mode_active_d, mode_req;
  logic signed [DATA_WIDTH-1:0]  dl_q [TAPS];
  logic signed [DATA_WIDTH-1:0]  dl_d [TAPS];
  logic signed [PW-1:0]          prod_q [TAPS];
  logic signed [PW-1:0]          prod_d [TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_q [TAPS];
  logic signed [COEFF_WIDTH-1:0] shadow_d [TAPS];
  logic signed [COEFF_WIDTH-1:0] active_q [TAPS];
  logic signed [COEFF_WIDTH-1:0] active_d [TAPS];
  logic signed [AW-1:0] f_q, f_d, acc, acc_r, f_calc;
  logic signed [OUT_WIDTH-1:0] y_q, y_d, fb, y_sat;
  logic signed [SW-1:0] sum;
  logic [SW-OUT_WIDTH:0] sum_hi;
  logic v1_q, v1_d, v2_q, v2_d, m_tvalid_q, m_tvalid_d, sat_q, sat_d;
  logic adv, s_fire, clamp;
  logic [1:0] rst_sync_q;
  logic rst_n;

  // Reset asserts immediately but releases two clocks after arst_n rises.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_comb begin
    mode_req = (mode == 2'b11) ? 2'b00 : mode;
    adv      = !m_tvalid_q || m_tready;
    s_tready = rst_n && (state_q == RUN) && (mode_req == mode_active_q) && adv;
    s_fire   = s_tvalid && s_tready;

    state_d       = state_q;
    mode_active_d = mode_active_q;
    dl_d          = dl_q;
    prod_d        = prod_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    f_d           = f_q;
    y_d           = y_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    m_tvalid_d    = m_tvalid_q;
    sat_d         = sat_q;

    if (coef_we && (int'(coef_addr) < TAPS)) shadow_d[coef_addr] = coef_data;
    if (coef_commit) active_d = shadow_d;

    // Products use the bank active before this edge's commit.
    if (s_fire) begin
      dl_d[0] = s_tdata;
      for (int k = 1; k < TAPS; k++) dl_d[k] = dl_q[k-1];
      for (int k = 0; k < TAPS; k++) prod_d[k] = PW'(active_q[k]) * PW'(dl_d[k]);
    end

    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + AW'(prod_q[k]);
    acc_r  = acc + RND;
    f_calc = acc_r >>> COEFF_FRAC;

    fb     = (mode_active_q == 2'b10) ? y_q : '0;
    sum    = SW'(f_q) + SW'(fb);
    sum_hi = sum[SW-1:OUT_WIDTH-1];
    clamp  = !((&sum_hi) || !(|sum_hi));
    if (clamp) y_sat = sum[SW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else       y_sat = sum[OUT_WIDTH-1:0];

    // While v1 holds a sample, dl_q[0] is still that sample, so bypass reads it there.
    if (adv) begin
      v1_d       = s_fire;
      v2_d       = v1_q;
      m_tvalid_d = v2_q;
      if (v1_q) f_d = (mode_active_q == 2'b00) ? AW'(dl_q[0]) : f_calc;
      if (v2_q) begin
        y_d = y_sat;
        if (clamp) sat_d = 1'b1;
      end
    end

    case (state_q)
      RUN:   if (mode_req != mode_active_q) state_d = DRAIN;
      DRAIN: if (!v1_q && !v2_q && !m_tvalid_q) state_d = CLEAR;
      CLEAR: begin
        for (int k = 0; k < TAPS; k++) begin
          dl_d[k]   = '0;
          prod_d[k] = '0;
        end
        f_d           = '0;
        y_d           = '0;
        sat_d         = 1'b0;
        mode_active_d = mode_req;
        state_d       = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      mode_active_q <= 2'b01;
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      m_tvalid_q    <= 1'b0;
      f_q           <= '0;
      y_q           <= '0;
      sat_q         <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        dl_q[k]     <= '0;
        prod_q[k]   <= '0;
        shadow_q[k] <= (k == 0) ? ONE : '0;
        active_q[k] <= (k == 0) ? ONE : '0;
      end
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode_active_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      m_tvalid_q    <= m_tvalid_d;
      f_q           <= f_d;
      y_q           <= y_d;
      sat_q         <= sat_d;
      dl_q          <= dl_d;
      prod_q        <= prod_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign m_tvalid    = m_tvalid_q;
  assign m_tdata     = y_q;
  assign mode_active = mode_active_q;
  assign sat_flag    = sat_q;
  assign busy        = (state_q != RUN);

endmodule

// File: tb/tb_adaptive_filter_pipe.sv
// Self-checking bench for adaptive_filter_pipe: directed steps plus random traffic,
// scored against a sample-level model of the filter arithmetic.
module tb_adaptive_filter_pipe;

  localparam int DW   = 14;
  localparam int CW   = 16;
  localparam int CF   = 14;
  localparam int TAPS = 8;
  localparam int OW   = 16;
  localparam int AWD  = $clog2(TAPS);
  localparam longint MAXO = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint MINO = -(longint'(1) <<< (OW - 1));

  logic clk = 1'b0;
  logic arst_n;
  logic [1:0] mode;
  logic s_tvalid, s_tready;
  logic signed [DW-1:0] s_tdata;
  logic m_tvalid, m_tready;
  logic signed [OW-1:0] m_tdata;
  logic coef_we;
  logic [AWD-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic coef_commit;
  logic [1:0] mode_active;
  logic sat_flag, busy;

  adaptive_filter_pipe #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .COEFF_FRAC(CF), .TAPS(TAPS), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .arst_n(arst_n), .mode(mode),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_commit(coef_commit),
    .mode_active(mode_active), .sat_flag(sat_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit last_sf;
  longint last_out;
  bit busy_prev;

  // Reference model: sample history, both coefficient banks, integrator memory.
  longint hist [TAPS];
  longint bank_act [TAPS];
  longint bank_sh [TAPS];
  longint yprev;
  bit model_sat;
  int model_mode;
  longint exp_q [$];

  task automatic checkOutput(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int mode_map(input int m);
    return (m == 3) ? 0 : m;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    yprev     = 0;
    model_sat = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    exp_q.delete();
    for (int k = 0; k < TAPS; k++) begin
      bank_act[k] = (k == 0) ? (longint'(1) <<< CF) : 0;
      bank_sh[k]  = bank_act[k];
    end
    model_mode = 1;
  endfunction

  // Output for one accepted sample, from the filter equations in plain arithmetic.
  function automatic longint model_out(input longint x);
    longint acc;
    longint v;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    if (model_mode == 0) return x;
    acc = 0;
    for (int k = 0; k < TAPS; k++) acc += bank_act[k] * hist[k];
    v = (acc + (longint'(1) <<< (CF - 1))) >>> CF;
    if (model_mode == 2) v += yprev;
    if (v > MAXO) begin
      v = MAXO;
      model_sat = 1;
    end else if (v < MINO) begin
      v = MINO;
      model_sat = 1;
    end
    if (model_mode == 2) yprev = v;
    return v;
  endfunction

  // One clock: drive inputs, observe handshakes before the edge, score after it.
  task automatic applyStimulus(input bit sv, input longint sd, input bit mr);
    logic sf, mf;
    logic signed [OW-1:0] md;
    s_tvalid = sv;
    s_tdata  = DW'(sd);
    m_tready = mr;
    @(negedge clk);
    sf = s_tvalid && s_tready;
    mf = m_tvalid && m_tready;
    md = m_tdata;
    @(posedge clk);
    #1;
    last_sf = sf;
    if (sf) exp_q.push_back(model_out(sd));
    if (mf) begin
      checkOutput("output_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) checkOutput("m_tdata", md, exp_q.pop_front());
      last_out = md;
    end
    if (busy_prev && !busy) begin
      model_clear();
      model_mode = mode_map(int'(mode));
    end
    busy_prev = busy;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      applyStimulus(1'b0, 0, 1'b1);
    end
    checkOutput("drain_complete", exp_q.size(), 0);
  endtask

  task automatic write_coef(input int addr, input longint val, input bit commit);
    coef_we     = 1'b1;
    coef_addr   = AWD'(addr);
    coef_data   = CW'(val);
    coef_commit = commit;
    applyStimulus(1'b0, 0, 1'b1);
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    bank_sh[addr] = val;
    if (commit) bank_act = bank_sh;
  endtask

  task automatic set_mode(input int m);
    mode = 2'(m);
    for (int i = 0; i < 40; i++) begin
      if (model_mode == mode_map(m) && !busy) break;
      applyStimulus(1'b0, 0, 1'b1);
    end
    checkOutput("mode_active", mode_active, mode_map(m));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic signed [OW-1:0] held;
    bit seen_busy, done7;

    arst_n = 1'b0; mode = 2'b01; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    busy_prev = 1'b0; last_out = 0; last_sf = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_m_tdata", m_tdata, 0);
    checkOutput("rst_sat_flag", sat_flag, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mode_active", mode_active, 1);
    checkOutput("rst_s_tready", s_tready, 0);
    arst_n = 1'b1;
    repeat (4) applyStimulus(1'b0, 0, 1'b1);

    // Impulse through identity coefficients, with latency checks.
    applyStimulus(1'b1, 100, 1'b1);
    checkOutput("impulse_accepted", last_sf, 1);
    checkOutput("latency_edge_k", m_tvalid, 0);
    applyStimulus(1'b0, 0, 1'b1);
    checkOutput("latency_edge_k1", m_tvalid, 0);
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("latency_edge_k2_valid", m_tvalid, 1);
    checkOutput("latency_edge_k2_data", m_tdata, 100);
    repeat (8) applyStimulus(1'b1, 0, 1'b1);
    drain();

    // Differentiator on a ramp.
    write_coef(0, 16384, 1'b0);
    write_coef(1, -16384, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 10 * i, 1'b1);
    drain();
    checkOutput("ramp_last", last_out, 10);

    // Random bank (last write shares the commit cycle), random handshakes.
    for (int k = 0; k < TAPS; k++)
      write_coef(k, longint'($urandom_range(0, 16383)) - 8192, k == TAPS - 1);
    for (int i = 0; i < 200; i++)
      applyStimulus(1'($urandom_range(0, 1)), longint'($urandom_range(0, 16383)) - 8192,
                    $urandom_range(0, 3) != 0);
    drain();

    // Backpressure with continuous input.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, longint'($urandom_range(0, 2000)), 1'b1);
    checkOutput("bp_valid_before_stall", m_tvalid, 1);
    held = m_tdata;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, longint'($urandom_range(0, 2000)), 1'b0);
      checkOutput("bp_s_tready_low", s_tready, 0);
      checkOutput("bp_m_tdata_stable", m_tdata, held);
    end
    drain();

    // Identity bank, integrator, then saturation.
    write_coef(0, 16384, 1'b0);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0, k == TAPS - 1);
    set_mode(2);
    repeat (3) applyStimulus(1'b1, 5, 1'b1);
    drain();
    checkOutput("integ_last", last_out, 15);
    repeat (8) applyStimulus(1'b1, 8191, 1'b1);
    drain();
    checkOutput("integ_saturated", last_out, 32767);
    checkOutput("sat_flag_set", sat_flag, 1);

    // Mode switch 10 -> 01 while samples are in flight.
    repeat (4) applyStimulus(1'b1, 3, 1'b1);
    mode = 2'b01;
    seen_busy = 1'b0;
    done7 = 1'b0;
    for (int i = 0; i < 40 && !done7; i++) begin
      applyStimulus(1'b1, seen_busy ? 7 : 3, 1'b1);
      if (busy) begin
        seen_busy = 1'b1;
        checkOutput("switch_s_tready_low", s_tready, 0);
      end
      if (last_sf && seen_busy) done7 = 1'b1;
    end
    checkOutput("switch_busy_seen", seen_busy, 1);
    checkOutput("switch_sample_accepted", done7, 1);
    drain();
    checkOutput("post_switch_out", last_out, 7);
    checkOutput("post_switch_sat_clear", sat_flag, 0);
    checkOutput("post_switch_mode", mode_active, 1);

    // Mode 11 behaves as bypass regardless of coefficients.
    write_coef(0, 5000, 1'b0);
    write_coef(3, -7000, 1'b1);
    set_mode(3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, longint'($urandom_range(0, 16383)) - 8192, 1'b1);
    drain();
    set_mode(1);

    // Reset mid-stream with a held output.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, longint'($urandom_range(0, 3000)), 1'b1);
    applyStimulus(1'b1, 123, 1'b0);
    checkOutput("pre_reset_valid", m_tvalid, 1);
    #2 arst_n = 1'b0;
    #1;
    checkOutput("midrst_m_tvalid", m_tvalid, 0);
    checkOutput("midrst_m_tdata", m_tdata, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_sat_flag", sat_flag, 0);
    checkOutput("midrst_mode_active", mode_active, 1);
    model_reset();
    busy_prev = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (3) applyStimulus(1'b0, 0, 1'b1);
    applyStimulus(1'b1, 50, 1'b1);
    applyStimulus(1'b1, -20, 1'b1);
    drain();
    checkOutput("post_reset_identity", last_out, -20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
